// File: rtl/sd_reg_arbiter.sv
// sd_reg_arbiter: round-robin arbiter sharing the SD host controller register port
// between the AXI slave bridge (m0) and the DMA/boot sequencer (m1), with bounded locking.
module sd_reg_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_valid,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_ready,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_valid,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ready,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_waddr,
    output logic [DATA_W-1:0] sd_wdata,
    output logic              sd_re,
    output logic [ADDR_W-1:0] sd_raddr,
    input  logic [DATA_W-1:0] sd_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t              state, state_nx;
    logic                owner, owner_held, last;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [2:0]          wait_cnt;
    logic [CNT_W-1:0]    lock_cnt;
    logic [1:0]          valid, lock;
    logic                lock_active, grant, win;

    assign valid = {m1_valid, m0_valid};
    assign lock  = {m1_lock, m0_lock};
    // A held lock only binds while the owner keeps its lock input asserted.
    assign lock_active = owner_held && lock[owner];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant = 1'b0;
        win   = 1'b0;
        if (state == IDLE && !rst_i) begin
            if (lock_active) begin
                grant = valid[owner];
                win   = owner;
            end else if (&valid) begin
                grant = 1'b1;
                win   = ~last;
            end else if (valid[0]) begin
                grant = 1'b1;
                win   = 1'b0;
            end else if (valid[1]) begin
                grant = 1'b1;
                win   = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ACCESS;
            ACCESS:  state_nx = we_q ? RESP : WAIT;
            WAIT:    if (wait_cnt == 3'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only; blocking here would race the comb next-state logic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            owner_held <= 1'b0;
            last       <= 1'b1;
            // NOTE: datapath latches are reset too, so controller address/data outputs read 0 after reset.
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
            lock_cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant) begin
                        we_q       <= win ? m1_we : m0_we;
                        addr_q     <= win ? m1_addr : m0_addr;
                        wdata_q    <= win ? m1_wdata : m0_wdata;
                        rdata_q    <= '0;
                        owner      <= win;
                        owner_held <= 1'b0;
                        lock_cnt   <= '0;
                    end else if (owner_held && !lock[owner]) begin
                        owner_held <= 1'b0;
                        lock_cnt   <= '0;
                    end else if (owner_held) begin
                        if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                            owner_held <= 1'b0;
                            lock_cnt   <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + CNT_W'(1);
                        end
                    end
                end
                ACCESS: if (!we_q) wait_cnt <= 3'(RD_LAT);
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) rdata_q <= sd_rdata;
                end
                RESP: begin
                    last       <= owner;
                    owner_held <= lock[owner];
                end
                default: ;
            endcase
        end
    end

    assign m0_ready     = grant && !win;
    assign m1_ready     = grant && win;
    assign sd_we        = (state == ACCESS) && we_q;
    assign sd_re        = (state == ACCESS) && !we_q;
    assign sd_waddr     = addr_q;
    assign sd_raddr     = addr_q;
    assign sd_wdata     = wdata_q;
    assign m0_rsp_valid = (state == RESP) && !owner;
    assign m1_rsp_valid = (state == RESP) && owner;
    assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Bench for sd_reg_arbiter: directed transactions, a cycle-schedule model checked every
// cycle, and hand-computed latency/ordering expectations.
module tb_sd_reg_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int RD_LAT   = 2;
    localparam int LOCK_MAX = 8;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic          v0 = 0, v1 = 0, we0 = 0, we1 = 0, lk0 = 0, lk1 = 0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata, sd_wdata, sd_rdata;
    logic [AW-1:0] sd_waddr, sd_raddr;
    logic          sd_we, sd_re, busy;

    sd_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_valid(v0), .m0_we(we0), .m0_addr(a0), .m0_wdata(d0), .m0_lock(lk0),
        .m0_ready(m0_ready), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_valid(v1), .m1_we(we1), .m1_addr(a1), .m1_wdata(d1), .m1_lock(lk1),
        .m1_ready(m1_ready), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .sd_we(sd_we), .sd_waddr(sd_waddr), .sd_wdata(sd_wdata),
        .sd_re(sd_re), .sd_raddr(sd_raddr), .sd_rdata(sd_rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file contents seen by a read; data is only driven RD_LAT cycles after sd_re.
    function automatic logic [DW-1:0] sd_val(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
    endfunction

    logic [AW:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= {sd_re, sd_raddr};
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign sd_rdata = rd_pipe[RD_LAT-1][AW] ? sd_val(rd_pipe[RD_LAT-1][AW-1:0]) : 32'hBAD0_BAD0;

    function automatic logic vin(input int m);  return (m == 0) ? v0 : v1;   endfunction
    function automatic logic lkin(input int m); return (m == 0) ? lk0 : lk1; endfunction

    // Schedule model: a granted access strobes one cycle after accept and responds
    // 2 (write) or 2+RD_LAT (read) cycles after accept; arbitration happens only when free.
    int            cyc = 0, t_acc = 0, who = 0, lk_who = 0, idle_cnt = 0, last_g = 1;
    bit            started = 0, txn_on = 0, t_we = 0, lk_held = 0;
    logic [AW-1:0] t_addr = '0, lat_addr = '0;
    logic [DW-1:0] lat_wdata = '0;

    always @(negedge clk) begin
        logic [1:0]    e_rdy, e_rsp;
        logic          e_we, e_re, e_busy;
        logic [DW-1:0] e_rdata;
        int            cand;
        e_rdy = '0; e_rsp = '0; e_we = 0; e_re = 0; e_busy = 0; e_rdata = '0; cand = -1;
        if (started) begin
            if (txn_on) begin
                e_busy = 1'b1;
                if (cyc == t_acc + 1) begin
                    e_we = t_we;
                    e_re = !t_we;
                end
                if (cyc == t_acc + (t_we ? 2 : 2 + RD_LAT)) begin
                    e_rsp[who] = 1'b1;
                    e_rdata    = t_we ? '0 : sd_val(t_addr);
                end
            end else if (!rst_i) begin
                if (lk_held && !lkin(lk_who)) lk_held = 0;
                if (lk_held) begin
                    if (vin(lk_who)) cand = lk_who;
                end else if (v0 && v1) cand = 1 - last_g;
                else if (v0) cand = 0;
                else if (v1) cand = 1;
                if (cand >= 0) e_rdy[cand] = 1'b1;
            end
            check("m0_ready", m0_ready, e_rdy[0]);
            check("m1_ready", m1_ready, e_rdy[1]);
            check("m0_rsp_valid", m0_rsp_valid, e_rsp[0]);
            check("m1_rsp_valid", m1_rsp_valid, e_rsp[1]);
            check("sd_we", sd_we, e_we);
            check("sd_re", sd_re, e_re);
            check("busy", busy, e_busy);
            check("sd_waddr", sd_waddr, lat_addr);
            check("sd_raddr", sd_raddr, lat_addr);
            check("sd_wdata", sd_wdata, lat_wdata);
            if (e_rsp[0]) check("m0_rsp_rdata", m0_rsp_rdata, e_rdata);
            if (e_rsp[1]) check("m1_rsp_rdata", m1_rsp_rdata, e_rdata);
        end
        if (rst_i) begin
            txn_on = 0; lk_held = 0; idle_cnt = 0; last_g = 1;
            lat_addr = '0; lat_wdata = '0; started = 1;
        end else if (started) begin
            if (txn_on && e_rsp != 2'b00) begin
                txn_on = 0; last_g = who; lk_held = lkin(who); lk_who = who; idle_cnt = 0;
            end else if (!txn_on) begin
                if (cand >= 0) begin
                    txn_on = 1; who = cand; t_acc = cyc; idle_cnt = 0;
                    t_we      = (cand == 0) ? we0 : we1;
                    t_addr    = (cand == 0) ? a0 : a1;
                    lat_addr  = t_addr;
                    lat_wdata = (cand == 0) ? d0 : d1;
                end else if (lk_held) begin
                    idle_cnt++;
                    if (idle_cnt == LOCK_MAX) begin
                        lk_held = 0; idle_cnt = 0;
                    end
                end
            end
        end
        cyc++;
    end

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic wait_ready(input int m, output int t);
        bit seen = 0;
        t = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ready : m1_ready) begin
                seen = 1;
                t = pcyc;
            end
        end
        check($sformatf("m%0d_ready_seen", m), seen, 1);
    endtask

    task automatic wait_rsp(input int m, output int t, output logic [DW-1:0] d);
        bit seen = 0;
        t = -1;
        d = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_rsp_valid : m1_rsp_valid) begin
                seen = 1;
                t = pcyc;
                d = (m == 0) ? m0_rsp_rdata : m1_rsp_rdata;
            end
        end
        check($sformatf("m%0d_rsp_seen", m), seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int            t0, t1, t2, ng, gseq, nr0, nr1, first, lastg, t_m1, t_m0;
        logic [DW-1:0] rd;

        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sd_we", sd_we, 0);
        check("rst_sd_waddr", sd_waddr, 0);

        // Single write from m0.
        @(posedge clk); #1;
        v0 = 1; we0 = 1; a0 = 32'h08; d0 = 32'hDEAD_BEEF; lk0 = 0;
        wait_ready(0, t0);
        @(posedge clk); #1 v0 = 0;
        @(negedge clk);
        check("t1_sd_we", sd_we, 1);
        check("t1_waddr", sd_waddr, 32'h08);
        check("t1_wdata", sd_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_rsp", m0_rsp_valid, 1);
        check("t1_rdata", m0_rsp_rdata, 0);

        // Read from m1 with RD_LAT=2.
        @(posedge clk); #1;
        v1 = 1; we1 = 0; a1 = 32'h10; lk1 = 0;
        wait_ready(1, t0);
        @(posedge clk); #1 v1 = 0;
        @(negedge clk);
        check("t2_sd_re", sd_re, 1);
        check("t2_raddr", sd_raddr, 32'h10);
        wait_rsp(1, t1, rd);
        check("t2_latency", t1 - t0, 4);
        check("t2_rdata", rd, 32'h1234_5678);

        // Both valid, no lock: grants alternate.
        @(posedge clk); #1;
        v0 = 1; we0 = 1; a0 = 32'h20; d0 = 32'h1111;
        v1 = 1; we1 = 1; a1 = 32'h24; d1 = 32'h2222;
        ng = 0; gseq = 0; nr0 = 0; nr1 = 0; first = 0; lastg = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (m0_rsp_valid) nr0++;
            if (m1_rsp_valid) nr1++;
            if (m0_ready || m1_ready) begin
                gseq = gseq * 10 + (m1_ready ? 2 : 1);
                if (ng == 0) first = pcyc;
                lastg = pcyc;
                ng++;
            end
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        repeat (2) begin
            @(negedge clk);
            if (m0_rsp_valid) nr0++;
            if (m1_rsp_valid) nr1++;
        end
        check("t3_grant_order", gseq, 1212);
        check("t3_accept_spacing", lastg - first, 9);
        check("t3_m0_rsps", nr0, 2);
        check("t3_m1_rsps", nr1, 2);

        // m1 locks across three writes while m0 waits.
        @(posedge clk); #1;
        v1 = 1; we1 = 1; a1 = 32'h04; d1 = 32'hA; lk1 = 1;
        ng = 0; gseq = 0; t_m1 = 0; t_m0 = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                gseq = gseq * 10 + (m1_ready ? 2 : 1);
                if (m1_ready) t_m1 = pcyc;
                if (m0_ready) t_m0 = pcyc;
                ng++;
                @(posedge clk); #1;
                case (ng)
                    1: begin a1 = 32'h00; d1 = 32'hB; v0 = 1; we0 = 1; a0 = 32'h30; d0 = 32'hC; end
                    2: d1 = 32'hD;
                    3: begin v1 = 0; lk1 = 0; end
                    default: v0 = 0;
                endcase
            end
        end
        check("t4_grant_order", gseq, 2221);
        check("t4_m0_after_unlock", t_m0 - t_m1, 3);
        wait_rsp(0, t1, rd);

        // m0 holds its lock while idle; m1 waits for the timeout.
        @(posedge clk); #1;
        v0 = 1; we0 = 1; a0 = 32'h50; d0 = 32'h5; lk0 = 1;
        wait_ready(0, t0);
        @(posedge clk); #1;
        v0 = 0; v1 = 1; we1 = 1; a1 = 32'h54; d1 = 32'h6; lk1 = 0;
        wait_rsp(0, t1, rd);
        wait_ready(1, t2);
        check("t5_lock_timeout", t2 - t1, 9);
        @(posedge clk); #1;
        v1 = 0; lk0 = 0;
        wait_rsp(1, t1, rd);

        // Reset during the WAIT of a read abandons it.
        @(posedge clk); #1;
        v0 = 1; we0 = 0; a0 = 32'h10;
        wait_ready(0, t0);
        @(posedge clk); #1 v0 = 0;
        @(posedge clk); #1;
        rst_i = 1;
        v0 = 1; we0 = 1; a0 = 32'h60; d0 = 32'h7;
        v1 = 1; we1 = 1; a1 = 32'h64; d1 = 32'h8;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_sd_re", sd_re, 0);
        check("t6_sd_raddr", sd_raddr, 0);
        check("t6_m0_ready", m0_ready, 0);
        check("t6_m1_ready", m1_ready, 0);
        check("t6_m0_rsp", m0_rsp_valid, 0);
        @(posedge clk); #1 rst_i = 0;
        @(negedge clk);
        check("t6_first_grant_m0", m0_ready, 1);
        check("t6_first_grant_not_m1", m1_ready, 0);
        check("t6_no_stale_rsp", m0_rsp_valid, 0);
        @(posedge clk); #1 v0 = 0;
        wait_ready(1, t0);
        @(posedge clk); #1 v1 = 0;
        wait_rsp(1, t1, rd);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_reg_arbiter.md
Name: sd_reg_arbiter

Overview:
- Shares the single register port of the SD host controller between two requesters: requester 0 is the AXI slave bridge (CPU path), requester 1 is the DMA/boot sequencer.
- Sequences each access as one strobe on the controller port, then waits a fixed read latency and returns a response to the winner.
- Arbitration is round-robin. A requester may lock the port so that multi-register command sequences (argument write, then command write) are not interleaved; the lock is bounded by a timeout.

Parameters:
- ADDR_W, 32, register address width.
- DATA_W, 32, register data width.
- RD_LAT, 1, cycles from the sd_re strobe to valid sd_rdata (legal range 1..7).
- LOCK_MAX, 64, idle cycles a lock may be held with no request before it is released.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- m0_valid / m1_valid  in  1  access request; held until the matching ready.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  register address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_lock / m1_lock  in  1  keep ownership after this access.
- m0_ready / m1_ready  out  1  one-cycle accept pulse.
- m0_rsp_valid / m1_rsp_valid  out  1  one-cycle completion pulse.
- m0_rsp_rdata / m1_rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes.
- sd_we  out  1  controller write strobe.
- sd_waddr  out  ADDR_W  controller write address.
- sd_wdata  out  DATA_W  controller write data.
- sd_re  out  1  controller read strobe.
- sd_raddr  out  ADDR_W  controller read address.
- sd_rdata  in  DATA_W  controller read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs go to 0; FSM goes to IDLE.
  - Round-robin pointer is set so requester 0 has priority.
  - Owner is cleared and the lock counter is set to 0.
  - Any in-flight access is abandoned: no rsp_valid is issued for it.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, winner selection:
  - If an owner is locked, only the owner's valid is considered.
  - Otherwise, a single valid requester wins.
  - If both are valid, the requester not granted last wins.
- IDLE, accept:
  - The winner's ready is driven combinationally high in the same cycle; that is the accept.
  - we, addr and wdata are latched; owner := winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - Write: sd_we=1 and sd_waddr/sd_wdata come from the latch; next state RESP.
  - Read: sd_re=1 and sd_raddr comes from the latch; load the wait counter with RD_LAT; next state WAIT.
  - Address and data outputs hold their latched values outside the strobe cycle.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0 (i.e. RD_LAT cycles after the sd_re cycle), capture sd_rdata and go to RESP.
- RESP:
  - The owner's rsp_valid is 1 for one cycle, with rsp_rdata (captured read data, or 0 for a write).
  - Set the last-granted pointer to the owner.
  - If the owner's lock is high this cycle, the lock is retained; otherwise the owner is cleared.
  - Next state IDLE.
- Latency:
  - Write: accept at cycle T, sd_we at T+1, rsp_valid at T+2.
  - Read: accept at T, sd_re at T+1, rsp_valid at T+2+RD_LAT.
  - Minimum spacing between accepts is 3 cycles for writes.
- Lock timeout:
  - While locked and in IDLE, the counter increments every cycle the owner's valid is low.
  - It resets to 0 on each accept.
  - When it reaches LOCK_MAX, the lock is released and the owner cleared in that same cycle; arbitration is normal from the next cycle.
  - Deasserting lock while idle also releases immediately.
- Boundary conditions:
  - A requester may drop valid before ready without side effects.
  - The losing requester sees ready=0 and must hold its request.
  - A non-owner's valid is ignored while the other requester holds a lock.
  - Both locks high with both valid and no owner: normal round-robin applies; the lock belongs to the winner only.
  - rsp_valid and ready are never both high for the same requester in the same cycle.
  - sd_we and sd_re are never both high in the same cycle.

Test Plan:
- Reset, then m0 writes addr 0x08, data 0xDEADBEEF → m0_ready at T; sd_we=1 with waddr 0x08 / wdata 0xDEADBEEF at T+1; m0_rsp_valid at T+2 with rdata 0.
- RD_LAT=2; m1 reads 0x10 while the model returns 0x12345678 → sd_re at T+1; m1_rsp_valid at T+4 with rdata 0x12345678.
- m0 and m1 both valid continuously, no lock → grants alternate m0, m1, m0, m1; each gets exactly one rsp per grant.
- m1 locks for three writes (0x04, 0x00, 0x00) while m0 is constantly valid → m1 gets all three accesses consecutively; m0 is granted first after m1 drops lock in RESP.
- LOCK_MAX=8; m0 locks then goes idle while m1 is valid → m1_ready asserts 9 cycles after m0's RESP (8 counted cycles plus 1 arbitration cycle).
- rst_i asserted in WAIT of a read → no rsp_valid; all outputs are 0 next cycle; the first grant after reset goes to m0 when both are valid.
